// File: rtl/boot_pkg.sv
// Shared types and default constants for the serial boot loader.
package boot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    READY,
    RUN,
    ERR
  } boot_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PAR,
    RX_STOP
  } rx_phase_t;

  localparam int unsigned DEF_DBIT       = 8;
  localparam int unsigned DEF_BIT_CLKS   = 16;
  localparam int unsigned DEF_PROG_BYTES = 20;
  localparam int unsigned FRAME_BITS     = DEF_DBIT + 3;

endpackage

// File: rtl/boot_uart_rx.sv
// Frame deserializer: start, DBIT data LSB-first, parity, stop.
// Parity checking only when BOOT_PARITY_EN is defined; frame length is the same either way.
module boot_uart_rx
  import boot_pkg::*;
#(
  parameter int unsigned DBIT     = DEF_DBIT,
  parameter int unsigned BIT_CLKS = DEF_BIT_CLKS
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            rx,
  output logic            byte_valid,
  output logic [DBIT-1:0] byte_data,
  output logic            par_err,
  output logic            frm_err,
  output logic            rx_busy,
  output logic            start_ok
);

  localparam int unsigned CW = $clog2(BIT_CLKS);
  localparam int unsigned BW = $clog2(DBIT);
  localparam logic [CW-1:0] HALF_CNT = CW'(BIT_CLKS / 2 - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(BIT_CLKS - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DBIT - 1);

  logic            r_rx_s1, r_rx_s2, r_rx_s3;
  rx_phase_t       r_phase;
  logic [CW-1:0]   r_cnt;
  logic [BW-1:0]   r_bit;
  logic [DBIT-1:0] r_shift;
  logic            r_valid, r_frm_err, r_start_ok;
`ifdef BOOT_PARITY_EN
  logic            r_par, r_par_err;
  assign par_err = r_par_err;
`else
  assign par_err = 1'b0;
`endif

  assign byte_valid = r_valid;
  assign byte_data  = r_shift;
  assign frm_err    = r_frm_err;
  assign start_ok   = r_start_ok;
  assign rx_busy    = (r_phase != RX_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_s3    <= 1'b1;
      r_phase    <= RX_IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_valid    <= 1'b0;
      r_frm_err  <= 1'b0;
      r_start_ok <= 1'b0;
`ifdef BOOT_PARITY_EN
      r_par      <= 1'b0;
      r_par_err  <= 1'b0;
`endif
    end else begin
      r_rx_s1    <= rx;
      r_rx_s2    <= r_rx_s1;
      r_rx_s3    <= r_rx_s2;
      r_valid    <= 1'b0;
      r_start_ok <= 1'b0;
      case (r_phase)
        RX_IDLE: begin
          if (r_rx_s3 && !r_rx_s2) begin
            r_phase <= RX_START;
            r_cnt   <= '0;
          end
        end
        RX_START: begin
          if (r_cnt == HALF_CNT) begin
            r_cnt <= '0;
            // Start bit high again at mid-bit: treat as a glitch.
            if (r_rx_s2) begin
              r_phase <= RX_IDLE;
            end else begin
              r_phase    <= RX_DATA;
              r_bit      <= '0;
              r_start_ok <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_cnt == FULL_CNT) begin
            r_cnt   <= '0;
            r_shift <= {r_rx_s2, r_shift[DBIT-1:1]};
            if (r_bit == LAST_BIT) r_phase <= RX_PAR;
            else                   r_bit   <= r_bit + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_PAR: begin
          if (r_cnt == FULL_CNT) begin
            r_cnt   <= '0;
            r_phase <= RX_STOP;
`ifdef BOOT_PARITY_EN
            r_par   <= r_rx_s2;
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_cnt == FULL_CNT) begin
            r_cnt     <= '0;
            r_phase   <= RX_IDLE;
            r_valid   <= 1'b1;
            r_frm_err <= !r_rx_s2;
`ifdef BOOT_PARITY_EN
            r_par_err <= (r_par != ^r_shift);
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_phase <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/boot_loader_ctrl.sv
// Boot loader: packs received bytes into 32-bit words, writes imem, releases the CPU on startbut.
// Optional parity checking via BOOT_PARITY_EN (in boot_uart_rx).
module boot_loader_ctrl
  import boot_pkg::*;
#(
  parameter int unsigned DBIT       = DEF_DBIT,
  parameter int unsigned BIT_CLKS   = DEF_BIT_CLKS,
  parameter int unsigned PROG_BYTES = DEF_PROG_BYTES,
  parameter int unsigned ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rx,
  input  logic              startbut,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned CNT_W = $clog2(PROG_BYTES + 1);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(PROG_BYTES - 1);

  logic            w_rx_valid, w_par_err, w_frm_err, w_rx_busy, w_start_ok;
  logic [DBIT-1:0] w_rx_data;
  logic [7:0]      w_byte;
  logic [31:0]     w_word_nx;
  logic            w_sb_rise;

  boot_state_t       r_state;
  logic              r_sb_s1, r_sb_s2, r_sb_s3;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_lane;
  logic [31:0]       r_word;
  logic              r_we, r_hold, r_done, r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;

  boot_uart_rx #(
    .DBIT     (DBIT),
    .BIT_CLKS (BIT_CLKS)
  ) u_rx (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx         (rx),
    .byte_valid (w_rx_valid),
    .byte_data  (w_rx_data),
    .par_err    (w_par_err),
    .frm_err    (w_frm_err),
    .rx_busy    (w_rx_busy),
    .start_ok   (w_start_ok)
  );

  assign w_sb_rise = r_sb_s2 && !r_sb_s3;
  assign w_byte    = 8'(w_rx_data);
  // Lane 0 starts a fresh word, so a short final word is zero-padded.
  assign w_word_nx = ((r_lane == 2'd0) ? 32'h0 : r_word) | (32'(w_byte) << {r_lane, 3'b000});

  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign cpu_hold   = r_hold;
  assign done       = r_done;
  assign err        = r_err;
  assign busy       = (r_state == LOAD) || (w_rx_busy && (r_state != ERR));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_sb_s1 <= 1'b0;
      r_sb_s2 <= 1'b0;
      r_sb_s3 <= 1'b0;
      r_cnt   <= '0;
      r_lane  <= '0;
      r_word  <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_hold  <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_sb_s1 <= startbut;
      r_sb_s2 <= r_sb_s1;
      r_sb_s3 <= r_sb_s2;
      r_we    <= 1'b0;
      if (r_we) r_addr <= r_addr + 1'b1;
      case (r_state)
        // A confirmed start bit (not a bare falling edge) opens the load, so glitches stay idle.
        IDLE: if (w_start_ok) r_state <= LOAD;
        LOAD: begin
          if (w_rx_valid) begin
            if (w_par_err || w_frm_err) begin
              r_state <= ERR;
              r_err   <= 1'b1;
            end else begin
              r_word <= w_word_nx;
              r_lane <= r_lane + 1'b1;
              r_cnt  <= r_cnt + 1'b1;
              if (r_lane == 2'd3 || r_cnt == LAST_BYTE) begin
                r_we    <= 1'b1;
                r_wdata <= w_word_nx;
              end
              if (r_cnt == LAST_BYTE) begin
                r_state <= READY;
                r_done  <= 1'b1;
              end
            end
          end
        end
        READY: begin
          if (w_sb_rise) begin
            r_state <= RUN;
            r_hold  <= 1'b0;
          end
        end
        RUN, ERR: ;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Scoreboard bench for boot_loader_ctrl; expectations follow BOOT_PARITY_EN when defined.
module tb_boot_loader_ctrl;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    logic        done;
  } wr_t;

  logic        clk, reset_n, rx, startbut;
  logic        imem_we, cpu_hold, busy, done, err;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;

  int n_checks = 0;
  int n_errors = 0;
  wr_t exp_q[$];

  logic [7:0]  img   [20] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA,
                              8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
  logic [31:0] words [5]  = '{32'h44332211, 32'h88776655, 32'hCCBBAA99, 32'h10FFEEDD, 32'h14131211};

  boot_loader_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx         (rx),
    .startbut   (startbut),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && imem_we) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: got addr %h data %h expected none", imem_addr, imem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(imem_addr), 32'(e.addr));
        chk("wr_data", imem_wdata, e.data);
        chk("wr_done", 32'(done), 32'(e.done));
      end
    end
  end

  // Frame bits 0..10: start, data LSB-first, even parity, stop.
  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                            input int nbits);
    logic [10:0] f;
    f = {~bad_stop, (^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      rx = f[i];
      repeat (16) @(negedge clk);
    end
  endtask

  task automatic send_range(input int first, input int last);
    for (int i = first; i <= last; i++) send_frame(img[i], 1'b0, 1'b0, 11);
  endtask

  task automatic push_words(input int n, input bit full);
    for (int i = 0; i < n; i++) exp_q.push_back('{8'(i), words[i], full && (i == 4)});
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_we"}, 32'(imem_we), 0);
    chk({tag, "_addr"}, 32'(imem_addr), 0);
    chk({tag, "_wdata"}, imem_wdata, 0);
    chk({tag, "_hold"}, 32'(cpu_hold), 1);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    startbut = 1'b1;
    @(negedge clk);
    startbut = 1'b0;
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rx = 1'b1;
    startbut = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("rst_init");
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_vals("post_rst");

    // Short low pulse on rx: rejected at the mid-start re-sample.
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    chk("glitch_busy_mid", 32'(busy), 1);
    repeat (20) @(negedge clk);
    chk("glitch_busy_end", 32'(busy), 0);
    chk("glitch_no_write", exp_q.size(), 0);

    pulse_start();
    repeat (5) @(negedge clk);
    chk("idle_start_hold", 32'(cpu_hold), 1);

    // Full image, back-to-back frames; startbut pulsed mid-load.
    push_words(5, 1'b1);
    send_range(0, 2);
    pulse_start();
    repeat (4) @(negedge clk);
    chk("load_start_hold", 32'(cpu_hold), 1);
    chk("load_busy", 32'(busy), 1);
    send_range(3, 19);
    chk("load_q_empty", exp_q.size(), 0);
    chk("load_done", 32'(done), 1);
    chk("load_hold", 32'(cpu_hold), 1);
    chk("load_err", 32'(err), 0);
    chk("load_busy_end", 32'(busy), 0);

    // cpu_hold falls on the third edge after startbut rises.
    startbut = 1'b1;
    @(negedge clk);
    startbut = 1'b0;
    chk("run_hold_c1", 32'(cpu_hold), 1);
    @(negedge clk);
    chk("run_hold_c2", 32'(cpu_hold), 1);
    @(negedge clk);
    chk("run_hold_c3", 32'(cpu_hold), 0);
    pulse_start();
    repeat (5) @(negedge clk);
    chk("run_second_pulse", 32'(cpu_hold), 0);
    chk("run_done", 32'(done), 1);

    // Reset in the middle of byte 10, then full reload from address 0.
    do_reset();
    push_words(2, 1'b0);
    send_range(0, 8);
    send_frame(img[9], 1'b0, 1'b0, 5);
    chk("mid_q_empty", exp_q.size(), 0);
    reset_n = 1'b0;
    rx = 1'b1;
    #1;
    check_reset_vals("mid_rst");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    push_words(5, 1'b1);
    send_range(0, 19);
    chk("reload_q_empty", exp_q.size(), 0);
    chk("reload_done", 32'(done), 1);

    // Byte 7 with inverted parity.
    do_reset();
`ifdef BOOT_PARITY_EN
    push_words(1, 1'b0);
    send_range(0, 6);
    send_frame(img[7], 1'b1, 1'b0, 10);
    rx = 1'b1;
    repeat (11) @(negedge clk);
    chk("par_err_before", 32'(err), 0);
    @(negedge clk);
    chk("par_err_rise", 32'(err), 1);
    repeat (4) @(negedge clk);
    pulse_start();
    repeat (5) @(negedge clk);
    chk("par_start_ignored", 32'(cpu_hold), 1);
    send_range(8, 11);
    chk("par_q_empty", exp_q.size(), 0);
    chk("par_done", 32'(done), 0);
    chk("par_err_sticky", 32'(err), 1);
`else
    push_words(5, 1'b1);
    send_range(0, 6);
    send_frame(img[7], 1'b1, 1'b0, 11);
    send_range(8, 19);
    chk("par_q_empty", exp_q.size(), 0);
    chk("par_done", 32'(done), 1);
    chk("par_err", 32'(err), 0);
`endif

    // Stop bit 0 on byte 3: error, word 0 never written.
    do_reset();
    send_range(0, 2);
    send_frame(img[3], 1'b0, 1'b1, 11);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    chk("frm_err", 32'(err), 1);
    chk("frm_hold", 32'(cpu_hold), 1);
    chk("frm_done", 32'(done), 0);
    chk("frm_q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/boot_loader_ctrl.md
# boot_loader_ctrl

Serial program loader and CPU start sequencer between the board `rx` pin / `startbut` button and the CPU core. Deserializes the fixed frame (start, DBIT data LSB-first, even parity, stop), packs bytes little-endian into 32-bit instruction words and writes them to instruction memory. After PROG_BYTES bytes it releases the CPU when `startbut` is pressed. The CPU is held in reset until then.

## Interface
- DBIT, 8: data bits per frame
- BIT_CLKS, 16: clock cycles per serial bit, ≥4
- PROG_BYTES, 20: bytes per program image, ≥1
- ADDR_W, 8: instruction-memory word-address width

- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset; one clock, no other clock domains
- rx  in  1  serial input, idle high, asynchronous
- startbut  in  1  start button, asynchronous, active-high
- imem_we  out  1  one-cycle word write strobe
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  instruction word
- cpu_hold  out  1  high keeps CPU in reset
- busy  out  1  frame reception or load in progress
- done  out  1  full image loaded
- err  out  1  sticky parity/framing error

## Operation
- `rx` and `startbut` each pass through a 2-FF synchronizer.
- Deserializer: a falling edge on synced `rx` starts a frame. At BIT_CLKS/2 the start bit is re-sampled; if high, the frame is a glitch and is discarded. Then data, parity and stop bits are sampled every BIT_CLKS cycles at mid-bit. After the stop sample it emits `byte_valid` (1 cycle), `byte_data`, `par_err` (parity bit ≠ XOR of data bits) and `frm_err` (stop = 0).
- Controller states:
  - IDLE: entered on reset.
  - LOAD: entered on the first start edge.
  - READY: all PROG_BYTES received.
  - RUN: entered on a synced `startbut` rising edge while in READY.
  - ERR: entered on `par_err` or `frm_err` from any load state.
- Packing: byte k of the image goes to bits [8*(k%4)+7 : 8*(k%4)] of word k/4, so the first byte lands in [7:0]. `imem_we` fires when the 4th byte of a word arrives, or when the last byte arrives. A partial last word is zero-padded. `imem_addr` starts at 0 and increments after each write. It wraps modulo 2^ADDR_W with no error.
- ERR drops the erroneous byte and stops writing, so partial words are never written. `err=1`, `cpu_hold=1`, and all further `rx` and `startbut` input is ignored until reset.
- `startbut` is ignored in IDLE, LOAD and RUN. RUN is terminal: `cpu_hold=0` until reset.
- `busy=1` in LOAD, and also whenever the deserializer is mid-frame.
- Reset values: `imem_we=0`, `imem_addr=0`, `imem_wdata=0`, `cpu_hold=1`, `busy=0`, `done=0`, `err=0`. Byte count and shift register are cleared. Reset mid-frame aborts the frame, and the next load restarts at address 0.

## Timing
- `byte_valid` is asserted 2 cycles (synchronizer) after the mid-stop-bit sample.
- `imem_we`/`imem_addr`/`imem_wdata` are registered and valid together in the cycle after the completing `byte_valid`.
- `done` rises in the same cycle as the final `imem_we`.
- `cpu_hold` falls 3 cycles after `startbut` rises: 2 sync cycles plus 1 registered.
- `err` rises 1 cycle after the offending `byte_valid`.
- Back-to-back frames with zero idle bits are accepted. A start edge is detected in the cycle after the stop sample.

## Configuration
- `BOOT_PARITY_EN` defined: `par_err` is computed and drives ERR.
- `BOOT_PARITY_EN` undefined: the parity bit is still sampled as part of the frame but discarded, `par_err` is tied 0, and only framing errors set `err`. Frame length is identical in both builds.

## Structure
- Package `boot_pkg` holds:
  - state enum `boot_state_t` (IDLE, LOAD, READY, RUN, ERR);
  - deserializer phase enum (RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP);
  - default constants DBIT, BIT_CLKS, PROG_BYTES;
  - localparam FRAME_BITS = DBIT+3.
- Sub-module `boot_uart_rx` holds the synchronizer, bit-timing counter, shift register and error flags. `boot_loader_ctrl` holds the FSM, packing, address counter and start synchronizer.

## Test plan
- 20 bytes 0x11,0x22,…,0x14 with correct parity, BIT_CLKS=16 → 5 writes at addr 0–4, word0=0x44332211. `done=1`, `cpu_hold=1`, `err=0`.
- After the above, 1-cycle `startbut` pulse → `cpu_hold` 1→0 exactly 3 cycles later. A second pulse has no effect.
- Byte 7 sent with inverted parity (BOOT_PARITY_EN defined) → only addr 0 written, `err=1` one cycle after its `byte_valid`, `startbut` ignored. With the macro undefined → normal load, `err=0`.
- `rx` low for 4 cycles, then high → no byte counted, no write, `busy` returns to 0.
- `reset_n` pulsed low during byte 10 → all outputs at reset values. A full 20-byte reload then writes addr 0–4 again.
- `startbut` pulsed during LOAD and in IDLE → ignored. A stop bit driven 0 on byte 3 → `err=1`, no write.
